// File: rtl/mem_copy_master.sv
// -----------------------------------------------------------------------------
// mem_copy_master
//
// Bus initiator that copies a block of 32-bit words from one memory region to
// another over the valid/ready memory interface served by the BRAM controller.
// Each word is moved as one read followed by one write. A one-cycle idle gap
// separates consecutive requests so that a responder returning to idle after
// an acknowledge never sees a stale request.
//
// Ports:
//   clk         system clock, the only clock in the block
//   reset       synchronous, active-high reset
//   start       one-cycle copy request, sampled only when idle
//   src_addr    source byte address (bits [1:0] ignored)
//   dst_addr    destination byte address (bits [1:0] ignored)
//   len_words   number of words to copy
//   busy        high from the cycle after an accepted start until done
//   done        one-cycle completion pulse, on success or on timeout abort
//   error       timeout flag, sticky until the next accepted start
//   words_done  number of words whose write has been acknowledged
//   mem_valid   request strobe
//   mem_ready   responder acknowledge (ignored while mem_valid is low)
//   mem_addr    word-aligned request address
//   mem_wdata   write data (holds the last data value during reads)
//   mem_wstrb   4'b0000 for a read, 4'b1111 for a write
//   mem_rdata   read data, valid in the cycle mem_ready is high
// -----------------------------------------------------------------------------
module mem_copy_master #(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_done,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        GAP_W,
        WR,
        GAP_R,
        FIN
    } state_t;

    // Wait counter is wide enough to hold TIMEOUT_CYCLES; the abort fires on
    // the edge that closes the TIMEOUT_CYCLES-th unacknowledged cycle.
    localparam int               WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic [31:0]        src_q;
    logic [31:0]        dst_q;
    logic [LEN_W-1:0]   len_q;
    logic [31:0]        data_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [LEN_W-1:0]   words_next;

    assign words_next = words_done + LEN_W'(1);

    // NOTE: all state lives in this one clocked block and is updated with
    // non-blocking assignments, so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every register, data path included, is cleared: all
            // outputs must read 0 after reset and a reset mid-transfer must
            // drop mem_valid at that edge without a done pulse.
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            data_q     <= '0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            words_done <= '0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        src_q      <= {src_addr[31:2], 2'b00};
                        dst_q      <= {dst_addr[31:2], 2'b00};
                        len_q      <= len_words;
                        error      <= 1'b0;
                        words_done <= '0;
                        busy       <= 1'b1;
                        if (len_words == '0) begin
                            // Empty copy: finish without touching the bus.
                            state <= FIN;
                        end else begin
                            state     <= RD;
                            mem_valid <= 1'b1;
                            mem_wstrb <= 4'b0000;
                            mem_addr  <= {src_addr[31:2], 2'b00};
                            wait_cnt  <= '0;
                        end
                    end
                end

                RD: begin
                    if (mem_ready) begin
                        data_q    <= mem_rdata;
                        mem_valid <= 1'b0;
                        state     <= GAP_W;
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_valid <= 1'b0;
                        error     <= 1'b1;
                        state     <= FIN;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                GAP_W: begin
                    state     <= WR;
                    mem_valid <= 1'b1;
                    mem_wstrb <= 4'b1111;
                    mem_addr  <= dst_q;
                    mem_wdata <= data_q;
                    wait_cnt  <= '0;
                end

                WR: begin
                    if (mem_ready) begin
                        mem_valid  <= 1'b0;
                        words_done <= words_next;
                        // Address arithmetic wraps modulo 2^32 by width.
                        src_q      <= src_q + 32'd4;
                        dst_q      <= dst_q + 32'd4;
                        state      <= (words_next == len_q) ? FIN : GAP_R;
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_valid <= 1'b0;
                        error     <= 1'b1;
                        state     <= FIN;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                GAP_R: begin
                    state     <= RD;
                    mem_valid <= 1'b1;
                    mem_wstrb <= 4'b0000;
                    mem_addr  <= src_q;
                    wait_cnt  <= '0;
                end

                FIN: begin
                    // done is registered here, so it is seen in the cycle
                    // after FIN, together with busy falling.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_master.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_master
//
// Scoreboard bench for mem_copy_master. A BRAM-like responder serves the bus
// from a local word array. Each issued copy is expanded by a sequential
// reference model (read word i, write word i, addresses modulo 2^32) into an
// expected list of bus transfers and an expected completion record; an
// independent monitor pops and compares whenever the DUT completes a bus
// transfer or pulses done.
// -----------------------------------------------------------------------------
module tb_mem_copy_master;

    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 255;

    logic             clk;
    logic             reset;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len_words;
    logic             busy;
    logic             done;
    logic             error;
    logic [LEN_W-1:0] words_done;
    logic             mem_valid;
    logic             mem_ready;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wstrb;
    logic [31:0]      mem_rdata;

    mem_copy_master #(
        .LEN_W          (LEN_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len_words  (len_words),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_done (words_done),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- memory
    logic [31:0] bram    [0:1023];
    logic [31:0] ref_mem [0:1023];

    function automatic int idx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    // ------------------------------------------------------------- responder
    // Updates just after each rising edge so ready/rdata are stable for the
    // DUT's next edge and for the falling-edge monitor.
    bit never_ready = 1'b0;
    bit rand_lat    = 1'b0;
    bit junk_ready  = 1'b0;
    int rcnt        = 0;
    int rlat        = 2;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_valid === 1'b1 && !never_ready) begin
                if (rcnt >= rlat) begin
                    mem_ready = 1'b1;
                    if (mem_wstrb == 4'hF) bram[idx(mem_addr)] = mem_wdata;
                    else                   mem_rdata = bram[idx(mem_addr)];
                    rcnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                    rcnt++;
                end
            end else begin
                mem_ready = (mem_valid !== 1'b1 && junk_ready) ? 1'($urandom) : 1'b0;
                mem_rdata = $urandom;
                rcnt      = 0;
                rlat      = rand_lat ? int'($urandom_range(0, 3)) : 2;
            end
        end
    end

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_ev_t;

    typedef struct {
        logic [LEN_W-1:0] words;
        bit               err;
        int               cycles;    // busy length, -1 when timing is not fixed
        int               done_cyc;
    } done_ev_t;

    bus_ev_t  exp_bus  [$];
    done_ev_t exp_done [$];

    bus_ev_t  mon_ev;
    done_ev_t mon_de;
    int       busy_cnt = 0;

    always @(negedge clk) begin
        if (mem_valid === 1'b1 && mem_ready === 1'b1) begin
            if (exp_bus.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected: got transfer addr 0x%0h wstrb %b, want none", mem_addr, mem_wstrb);
            end else begin
                mon_ev = exp_bus.pop_front();
                check("bus_wstrb", 64'(mem_wstrb), mon_ev.wr ? 64'hF : 64'h0);
                check("bus_addr", 64'(mem_addr), 64'(mon_ev.addr));
                if (mon_ev.wr) check("bus_wdata", 64'(mem_wdata), 64'(mon_ev.data));
            end
        end
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            if (exp_done.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done pulse, want none (cycle %0d)", cyc);
            end else begin
                mon_de = exp_done.pop_front();
                check("done_words", 64'(words_done), 64'(mon_de.words));
                check("done_error", 64'(error), 64'(mon_de.err));
                check("done_busy_low", 64'(busy), 64'(1'b0));
                check("done_bus_drained", 64'(exp_bus.size()), 64'(0));
                if (mon_de.cycles >= 0) begin
                    check("done_cycle", 64'(cyc), 64'(mon_de.done_cyc));
                    check("busy_cycles", 64'(busy_cnt), 64'(mon_de.cycles));
                end
            end
        end
        if (busy !== 1'b1) busy_cnt = 0;
    end

    // ------------------------------------------------------- reference model
    // Sequential copy semantics: word i is read from src+4i then written to
    // dst+4i, in order, so overlapping regions resolve naturally.
    task automatic issue(input logic [31:0] s_in, input logic [31:0] d_in, input int len,
                         input bit timing_known, input bit expect_timeout);
        logic [31:0] s, d, sa, da, w;
        bus_ev_t     ev;
        done_ev_t    de;
        int          c;
        s = s_in & 32'hFFFF_FFFC;
        d = d_in & 32'hFFFF_FFFC;
        @(negedge clk);
        if (expect_timeout) begin
            de.words = '0;
            de.err   = 1'b1;
            c        = TIMEOUT + 1;
        end else begin
            for (int i = 0; i < len; i++) begin
                sa = s + 32'(4 * i);
                da = d + 32'(4 * i);
                w  = ref_mem[idx(sa)];
                ev.wr = 1'b0; ev.addr = sa; ev.data = 32'h0;
                exp_bus.push_back(ev);
                ev.wr = 1'b1; ev.addr = da; ev.data = w;
                exp_bus.push_back(ev);
                ref_mem[idx(da)] = w;
            end
            de.words = LEN_W'(len);
            de.err   = 1'b0;
            c        = (len == 0) ? 1 : 8 * len;
        end
        de.cycles   = timing_known ? c : -1;
        de.done_cyc = cyc + 1 + c;
        exp_done.push_back(de);
        src_addr  = s_in;
        dst_addr  = d_in;
        len_words = LEN_W'(len);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        // Scramble inputs: the DUT must work from its captured copies.
        src_addr  = $urandom;
        dst_addr  = $urandom;
        len_words = LEN_W'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_wait: got no done within %0d cycles, want done", n);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_error"}, 64'(error), 64'(0));
        check({tag, "_words_done"}, 64'(words_done), 64'(0));
        check({tag, "_mem_valid"}, 64'(mem_valid), 64'(0));
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        check({tag, "_mem_wstrb"}, 64'(mem_wstrb), 64'(0));
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        len_words = '0;
        for (int i = 0; i < 1024; i++) begin
            bram[i]    = 32'(i);
            ref_mem[i] = 32'(i);
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Basic copy of four words: done 32 cycles after acceptance.
        issue(32'h0000_0000, 32'h0000_0100, 4, 1'b1, 1'b0);
        wait_done();
        for (int i = 0; i < 4; i++) check("copy4_mem", 64'(bram[64 + i]), 64'(i));

        // Empty copy: no bus traffic, busy for exactly one cycle.
        issue(32'h0000_0000, 32'h0000_0000, 0, 1'b1, 1'b0);
        wait_done();

        // Misaligned addresses are forced to word alignment.
        issue(32'h0000_0002, 32'h0000_0203, 1, 1'b1, 1'b0);
        wait_done();

        // Responder never acknowledges: abort after TIMEOUT cycles.
        never_ready = 1'b1;
        issue(32'h0000_0040, 32'h0000_0500, 3, 1'b1, 1'b1);
        wait_done();
        never_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("error_sticky", 64'(error), 64'(1));
        issue(32'h0000_0010, 32'h0000_0600, 1, 1'b1, 1'b0);
        check("error_cleared", 64'(error), 64'(0));
        wait_done();

        // A second start in the middle of a copy is ignored.
        issue(32'h0000_0020, 32'h0000_0700, 2, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        src_addr  = 32'h0000_03F0;
        dst_addr  = 32'h0000_03F4;
        len_words = LEN_W'(7);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        wait_done();

        // Address wrap through 2^32 with overlapping regions.
        issue(32'hFFFF_FFF8, 32'hFFFF_FFFC, 3, 1'b1, 1'b0);
        wait_done();

        // Reset during the write of word 2 of 4; a start in the reset cycle
        // is lost.
        issue(32'h0000_0080, 32'h0000_0900, 4, 1'b1, 1'b0);
        repeat (13) @(negedge clk);
        reset     = 1'b1;
        start     = 1'b1;
        len_words = LEN_W'(1);
        @(negedge clk);
        check_all_zero("midreset");
        exp_bus.delete();
        exp_done.delete();
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = bram[i];
        repeat (20) @(negedge clk);
        check("lost_start_idle", 64'(busy), 64'(0));
        issue(32'h0000_0080, 32'h0000_0900, 4, 1'b1, 1'b0);
        wait_done();

        // Randomized copies with variable responder latency and stray ready
        // pulses while no request is pending.
        rand_lat   = 1'b1;
        junk_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            issue($urandom & 32'h0000_0FFF, $urandom & 32'h0000_0FFF,
                  int'($urandom_range(0, 6)), 1'b0, 1'b0);
            wait_done();
        end
        junk_ready = 1'b0;

        repeat (5) @(negedge clk);
        check("bus_left", 64'(exp_bus.size()), 64'(0));
        check("done_left", 64'(exp_done.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1);
    end

endmodule
